// File: rtl/matrix_load_sequencer_pkg.sv
// matrix_load_sequencer_pkg: shared states, size codes and bus geometry for the matrix load sequencer.
package matrix_load_sequencer_pkg;
    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int FLAT_W = MAX_N * MAX_N * DATA_W;

    localparam logic [2:0] SIZE_2X2 = 3'b010;
    localparam logic [2:0] SIZE_3X3 = 3'b011;
    localparam logic [2:0] SIZE_4X4 = 3'b100;
    localparam logic [2:0] SIZE_5X5 = 3'b101;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESULT} state_t;

    function automatic logic size_legal(input logic [2:0] sz);
        return (sz >= SIZE_2X2) && (sz <= SIZE_5X5);
    endfunction
endpackage

// File: rtl/matrix_load_sequencer_index_counter.sv
// matrix_index_counter: row/column walker over an n x n matrix, flags the last element.
module matrix_index_counter (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [2:0] n_i,
    output logic [2:0] r_o,
    output logic [2:0] c_o,
    output logic       last_o
);
    logic [2:0] r_q, c_q;
    wire        c_end = c_q == n_i - 3'd1;

    always_ff @(posedge clock) begin
        if (!reset_n || clr_i) begin
            r_q <= '0;
            c_q <= '0;
        end else if (adv_i) begin
            c_q <= c_end ? 3'd0 : c_q + 3'd1;
            r_q <= c_end ? r_q + 3'd1 : r_q;
        end
    end

    assign r_o    = r_q;
    assign c_o    = c_q;
    assign last_o = c_end && (r_q == n_i - 3'd1);
endmodule

// File: rtl/matrix_load_sequencer.sv
// matrix_load_sequencer: streams an n x n byte matrix into the ALU flat bus and holds its determinant.
// Optional WAIT watchdog enabled by DET_TIMEOUT_EN.
module matrix_load_sequencer
    import matrix_load_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        matrix_size,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [FLAT_W-1:0] A_flat,
    output logic [2:0]        size_out,
    input  logic [DATA_W-1:0] det_result,
    input  logic              det_done,
    input  logic              det_overflow,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              result_valid,
    input  logic              result_ack,
    output logic              busy,
    output logic              err_size,
    output logic              timeout
);
    state_t              state_q, state_d;
    logic [2:0]          n_q, n_d;
    logic [FLAT_W-1:0]   flat_q, flat_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                ovf_q, ovf_d, err_q, err_d, wfirst_q;
    logic                clr, adv, last;
    logic [2:0]          r, c;
    int                  idx;

    matrix_index_counter u_idx (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (clr),
        .adv_i   (adv),
        .n_i     (n_q),
        .r_o     (r),
        .c_o     (c),
        .last_o  (last)
    );

`ifdef DET_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          tmo_q, tmo_d;
    always_ff @(posedge clock) begin
        cnt_q <= (!reset_n || state_q != WAIT) ? '0 : cnt_q + 1'b1;
        tmo_q <= reset_n && tmo_d;
    end
    assign timeout = tmo_q;
`else
    localparam bit unused_timeout_cfg = TIMEOUT_CYCLES > 0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        flat_d  = flat_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        clr     = 1'b0;
        adv     = 1'b0;
        idx     = (int'(r) * MAX_N + int'(c)) * DATA_W;
`ifdef DET_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
                if (size_legal(matrix_size)) begin
                    n_d     = matrix_size;
                    flat_d  = '0;
                    clr     = 1'b1;
                    state_d = LOAD;
                end else begin
                    err_d = 1'b1;
                end
            end
            LOAD: if (in_valid) begin
                adv                    = 1'b1;
                flat_d[idx +: DATA_W] = in_data;
                state_d                = last ? WAIT : LOAD;
            end
            // The first WAIT cycle lets the ALU's size select settle, so done is not trusted yet.
            WAIT: if (!wfirst_q && det_done) begin
                res_d   = det_result;
                ovf_d   = det_overflow;
                state_d = RESULT;
            end
`ifdef DET_TIMEOUT_EN
            else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                res_d   = '0;
                ovf_d   = 1'b1;
                tmo_d   = 1'b1;
                state_d = RESULT;
            end
`endif
            RESULT: state_d = result_ack ? IDLE : RESULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            flat_q   <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            wfirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            flat_q   <= flat_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            wfirst_q <= state_q == LOAD && in_valid && last;
        end
    end

    assign in_ready     = state_q == LOAD;
    assign A_flat       = flat_q;
    assign size_out     = (state_q == WAIT || state_q == RESULT) ? n_q : 3'd0;
    assign result       = res_q;
    assign overflow     = ovf_q;
    assign result_valid = state_q == RESULT;
    assign busy         = state_q != IDLE;
    assign err_size     = err_q;
endmodule

// File: tb/tb_matrix_load_sequencer.sv
// tb_matrix_load_sequencer: directed + randomized bench with an array-based model of the packed matrix.
module tb_matrix_load_sequencer;
    logic         clock = 1'b0;
    logic         reset_n, start, in_valid, det_done, det_overflow, result_ack;
    logic [2:0]   matrix_size, size_out;
    logic [7:0]   in_data, det_result, result;
    logic         in_ready, overflow, result_valid, busy, err_size, timeout;
    logic [199:0] A_flat;
    logic [7:0]   mat[25];
    int           tests = 0, fails = 0;

    always #5 clock = ~clock;

    matrix_load_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .matrix_size(matrix_size),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .A_flat(A_flat),
        .size_out(size_out), .det_result(det_result), .det_done(det_done),
        .det_overflow(det_overflow), .result(result), .overflow(overflow),
        .result_valid(result_valid), .result_ack(result_ack), .busy(busy),
        .err_size(err_size), .timeout(timeout)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] model_flat(input int n);
        logic [199:0] f = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                f[(r * 5 + c) * 8 +: 8] = mat[r * n + c];
        return f;
    endfunction

    task automatic load_matrix(input int n, input bit gaps, output int beats);
        int budget = 0;
        beats = 0;
        start = 1'b1;
        matrix_size = 3'(n);
        tick();
        start = 1'b0;
        chk("load_ready", in_ready, 1);
        while (beats < n * n && budget < 500) begin
            logic hs;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = in_valid ? mat[beats] : 8'($urandom);
            hs = in_valid && in_ready;
            tick();
            if (hs) beats++;
            budget++;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_result(input logic [7:0] r, input logic o);
        int budget = 0;
        det_result = r;
        det_overflow = o;
        det_done = 1'b1;
        while (!result_valid && budget < 20) begin
            tick();
            budget++;
        end
        det_done = 1'b0;
        chk("res_valid", result_valid, 1);
        chk("res_value", result, r);
        chk("res_ovf", overflow, o);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_idle", busy, 0);
        chk("ack_rv", result_valid, 0);
    endtask

    initial begin
        int beats;
        logic [7:0] rv;
        reset_n = 1'b0; start = 0; matrix_size = 0; in_valid = 0; in_data = 0;
        det_result = 0; det_done = 0; det_overflow = 0; result_ack = 0;
        tick(); tick();
        chk("rst_flat", A_flat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_rv", result_valid, 0);
        reset_n = 1'b1;
        tick();

        // 2x2 directed
        mat[0] = 3; mat[1] = 1; mat[2] = 2; mat[3] = 4;
        load_matrix(2, 0, beats);
        chk("t1_beats", beats, 4);
        chk("t1_flat", A_flat, 200'h04020000000103);
        chk("t1_size", size_out, 2);
        chk("t1_ready", in_ready, 0);
        tick();
        chk("t1_wait_rv", result_valid, 0);
        finish_result(8'd10, 1'b0);
        chk("t1_size_idle", size_out, 0);
        chk("t1_flat_hold", A_flat, 200'h04020000000103);

        // 5x5 with random gaps, extra valid after the last beat must be refused
        for (int k = 0; k < 25; k++) mat[k] = 8'($urandom);
        load_matrix(5, 1, beats);
        chk("t2_beats", beats, 25);
        chk("t2_flat", A_flat, model_flat(5));
        in_valid = 1'b1;
        in_data = 8'hee;
        for (int k = 0; k < 3; k++) begin
            chk("t2_ready_low", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_flat_hold", A_flat, model_flat(5));
        chk("t2_size", size_out, 5);
        finish_result(8'($urandom), 1'b1);

        // random 3x3 and 4x4 loads
        for (int n = 3; n <= 4; n++) begin
            for (int k = 0; k < n * n; k++) mat[k] = 8'($urandom);
            load_matrix(n, 1, beats);
            chk("rnd_beats", beats, n * n);
            chk("rnd_flat", A_flat, model_flat(n));
            chk("rnd_size", size_out, n);
            finish_result(8'($urandom), 1'($urandom));
        end

        // illegal sizes
        for (int s = 0; s < 8; s++) begin
            if (s >= 2 && s <= 5) continue;
            start = 1'b1;
            matrix_size = 3'(s);
            tick();
            start = 1'b0;
            chk("t3_err", err_size, 1);
            chk("t3_busy", busy, 0);
            chk("t3_ready", in_ready, 0);
            tick();
            chk("t3_err_pulse", err_size, 0);
        end

        // reset mid-load
        start = 1'b1; matrix_size = 3'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin in_data = 8'(k + 7); tick(); end
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("t4_flat", A_flat, 0);
        chk("t4_size", size_out, 0);
        chk("t4_ready", in_ready, 0);
        chk("t4_result", result, 0);
        chk("t4_ovf", overflow, 0);
        chk("t4_rv", result_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_err", err_size, 0);
        chk("t4_tmo", timeout, 0);
        reset_n = 1'b1;
        tick();
        chk("t4_idle", busy, 0);

        // stale done on WAIT entry, held-off ack, ack together with start
        for (int k = 0; k < 4; k++) mat[k] = 8'($urandom);
        rv = 8'($urandom);
        det_result = rv; det_overflow = 1'b0; det_done = 1'b1;
        load_matrix(2, 0, beats);
        chk("t5_entry_rv", result_valid, 0);
        tick();
        chk("t5_cycle1_rv", result_valid, 0);
        chk("t5_cycle1_busy", busy, 1);
        tick();
        chk("t5_cycle2_rv", result_valid, 1);
        chk("t5_cycle2_res", result, rv);
        for (int k = 0; k < 10; k++) begin
            det_result = 8'($urandom); det_overflow = 1'b1;
            tick();
            chk("t5_hold_res", result, rv);
            chk("t5_hold_ovf", overflow, 0);
            chk("t5_hold_rv", result_valid, 1);
        end
        det_done = 1'b0;
        result_ack = 1'b1; start = 1'b1; matrix_size = 3'd3;
        tick();
        result_ack = 1'b0; start = 1'b0;
        chk("t5_ack_busy", busy, 0);
        chk("t5_ack_size", size_out, 0);
        chk("t5_ack_rv", result_valid, 0);
        tick();
        chk("t5_no_restart", busy, 0);
        chk("t5_flat_hold", A_flat, model_flat(2));

        // WAIT without det_done
        for (int k = 0; k < 4; k++) mat[k] = 8'($urandom);
        load_matrix(2, 0, beats);
`ifdef DET_TIMEOUT_EN
        begin
            int budget = 0;
            while (!timeout && budget < 20) begin tick(); budget++; end
            chk("t6_tmo", timeout, 1);
            chk("t6_rv", result_valid, 1);
            chk("t6_res", result, 0);
            chk("t6_ovf", overflow, 1);
            tick();
            chk("t6_tmo_pulse", timeout, 0);
            result_ack = 1'b1;
            tick();
            result_ack = 1'b0;
            chk("t6_idle", busy, 0);
        end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t6_no_tmo", timeout, 0);
        end
        chk("t6_still_wait", result_valid, 0);
        chk("t6_busy", busy, 1);
        finish_result(8'h5a, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matrix_load_sequencer.md
Name: matrix_load_sequencer

Overview:
- Upstream and downstream companion of the determinant ALU.
- Accepts matrix elements as a byte stream with a valid/ready handshake, packs them row-major into the 200-bit flat bus, and presents the matrix size.
- Waits for the ALU's done signal, then latches the determinant and overflow flag and holds them for the consumer until acknowledged.

Parameters:
DATA_W, 8, element width in bits.
MAX_N, 5, maximum matrix dimension; flat bus width = MAX_N*MAX_N*DATA_W = 200.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT (used only with DET_TIMEOUT_EN).

Ports:
clock  in  1  system clock; single clock domain.
reset_n  in  1  reset, synchronous, active-low.
start  in  1  begin a new load; sampled only in IDLE.
matrix_size  in  3  requested dimension; legal 3'b010..3'b101.
in_valid  in  1  element stream valid.
in_data  in  DATA_W  element value, row-major order.
in_ready  out  1  element stream ready.
A_flat  out  MAX_N*MAX_N*DATA_W  packed matrix to ALU.
size_out  out  3  matrix size to ALU.
det_result  in  DATA_W  ALU determinant.
det_done  in  1  ALU done.
det_overflow  in  1  ALU overflow.
result  out  DATA_W  latched determinant.
overflow  out  1  latched overflow.
result_valid  out  1  result available.
result_ack  in  1  consumer accepts result.
busy  out  1  high whenever state != IDLE.
err_size  out  1  one-cycle pulse on an illegal size at start.
timeout  out  1  one-cycle pulse on WAIT expiry (only with DET_TIMEOUT_EN; otherwise tied to 0).

Behaviour:
- Reset value of all outputs is 0: A_flat, size_out, in_ready, result, overflow, result_valid, busy, err_size, timeout. State resets to IDLE.
- Reset applied mid-operation aborts in the next cycle, with no partial result.
- Element (r,c) sits at A_flat[(r*MAX_N+c)*DATA_W +: DATA_W]. Unused positions are 0.
- IDLE:
  - in_ready=0.
  - start with a legal size: latch n, clear A_flat, set r=c=0, go to LOAD.
  - start with an illegal size (0, 1, 6, 7): err_size=1 for one cycle, stay in IDLE.
- LOAD:
  - in_ready=1 and size_out=0.
  - Each in_valid&&in_ready beat writes in_data at (r,c), then increments c. When c reaches n-1, c wraps to 0 and r increments.
  - The beat at (n-1,n-1) moves to WAIT; in_ready=0 from the next cycle.
  - Exactly n*n beats are accepted. Gaps in in_valid are allowed. start is ignored.
- WAIT:
  - size_out=n.
  - det_done is ignored in the first WAIT cycle, giving the ALU select one settle cycle.
  - From the second cycle on, det_done=1 latches det_result into result and det_overflow into overflow, and moves to RESULT.
- RESULT:
  - result_valid=1; result and overflow are held stable.
  - result_ack moves to IDLE with result_valid=0 and size_out=0 the next cycle.
  - start asserted together with result_ack is ignored; it must be re-asserted in IDLE.
- A_flat is held from load completion until the next legal start.
- Latency from the last element beat to result_valid is at least 2 cycles.

Optional Feature:
- Macro DET_TIMEOUT_EN.
- Defined: a counter clears on WAIT entry. If TIMEOUT_CYCLES elapse without det_done: timeout pulses for 1 cycle, result=0, overflow=1, go to RESULT.
- Undefined: WAIT waits indefinitely, there is no counter logic, and timeout is constant 0.

Decomposition:
- Shared package holds:
  - state enum IDLE/LOAD/WAIT/RESULT;
  - size constants SIZE_2X2=3'b010 .. SIZE_5X5=3'b101;
  - DATA_W, MAX_N, FLAT_W.
- One natural sub-module: matrix_index_counter, the r/c counter with wrap at n-1 and a last flag.

Test Plan:
1. 2x2, size 3'b010, stream 3,1,2,4:
   - A_flat bytes 0,1,5,6 = 3,1,2,4, all other bytes 0, size_out=2.
   - det_done with det_result=8'd10 gives result=10, result_valid=1.
2. 5x5, 25 beats with random in_valid gaps:
   - exactly 25 handshakes, byte k = element k, in_ready=0 after beat 25.
3. start with matrix_size=3'b111 -> err_size high for 1 cycle, busy stays 0, in_ready stays 0.
4. reset_n low after 3 beats of a 3x3 load -> next cycle all outputs 0, state IDLE.
5. det_done already high on WAIT entry (stale) -> not latched in WAIT cycle 1; captured in cycle 2. result_ack held off 10 cycles -> result stable throughout. result_ack together with start -> returns to IDLE, no new load starts.
6. With DET_TIMEOUT_EN and TIMEOUT_CYCLES=4, det_done never asserted -> timeout pulse, result=0, overflow=1, result_valid=1.
